// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one combinational ALU between two valid/ready requesters.
// Optional illegal-opcode screening is enabled by defining ALU_ARB_OPCHK_EN.
module alu_share_arbiter #(
    parameter int WIDTH = 32,
    parameter int OP_W  = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [WIDTH-1:0] req_a0,
    input  logic [WIDTH-1:0] req_a1,
    input  logic [WIDTH-1:0] req_b0,
    input  logic [WIDTH-1:0] req_b1,
    input  logic [OP_W-1:0]  req_op0,
    input  logic [OP_W-1:0]  req_op1,
    output logic [1:0]       resp_valid,
    input  logic [1:0]       resp_ready,
    output logic [WIDTH-1:0] resp_data,
    output logic             resp_err,
    output logic [WIDTH-1:0] alu_in1,
    output logic [WIDTH-1:0] alu_in2,
    output logic [OP_W-1:0]  alu_op,
    input  logic [WIDTH-1:0] alu_res
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_EXEC = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;

`ifdef ALU_ARB_OPCHK_EN
    function automatic logic op_illegal(input logic [OP_W-1:0] op);
        return (op > OP_W'(3'd4));
    endfunction
    logic err_q, err_d;
`endif

    logic [1:0]       state_q, state_d;
    logic             last_q, last_d;
    logic             owner_q, owner_d;
    logic [WIDTH-1:0] alu_in1_q, alu_in1_d;
    logic [WIDTH-1:0] alu_in2_q, alu_in2_d;
    logic [OP_W-1:0]  alu_op_q, alu_op_d;
    logic [1:0]       resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0] resp_data_q, resp_data_d;
    logic             resp_err_q, resp_err_d;

    logic             grant_s;
    logic [WIDTH-1:0] a_sel_s;
    logic [WIDTH-1:0] b_sel_s;
    logic [OP_W-1:0]  op_sel_s;

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        grant_s = 1'b0;
        case (req_valid)
            2'b01:   grant_s = 1'b0;
            2'b10:   grant_s = 1'b1;
            2'b11:   grant_s = ~last_q;
            default: grant_s = 1'b0;
        endcase
    end

    // Accept strobe and operand mux for the granted requester.
    always_comb begin
        req_ready = 2'b00;
        if ((state_q == S_IDLE) && (req_valid != 2'b00)) begin
            req_ready = grant_s ? 2'b10 : 2'b01;
        end else begin
            req_ready = 2'b00;
        end
        a_sel_s  = grant_s ? req_a1  : req_a0;
        b_sel_s  = grant_s ? req_b1  : req_b0;
        op_sel_s = grant_s ? req_op1 : req_op0;
    end

    // Next-state logic for the IDLE -> EXEC -> RESP sequence.
    always_comb begin
        state_d      = state_q;
        last_d       = last_q;
        owner_d      = owner_q;
        alu_in1_d    = alu_in1_q;
        alu_in2_d    = alu_in2_q;
        alu_op_d     = alu_op_q;
        resp_valid_d = resp_valid_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
`ifdef ALU_ARB_OPCHK_EN
        err_d        = err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (req_valid != 2'b00) begin
                    // ALU operand registers double as the request latch.
                    alu_in1_d = a_sel_s;
                    alu_in2_d = b_sel_s;
                    owner_d   = grant_s;
                    last_d    = grant_s;
                    state_d   = S_EXEC;
`ifdef ALU_ARB_OPCHK_EN
                    if (op_illegal(op_sel_s)) begin
                        alu_op_d = {OP_W{1'b0}};
                        err_d    = 1'b1;
                    end else begin
                        alu_op_d = op_sel_s;
                        err_d    = 1'b0;
                    end
`else
                    alu_op_d = op_sel_s;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_EXEC: begin
`ifdef ALU_ARB_OPCHK_EN
                if (err_q) begin
                    resp_data_d = {WIDTH{1'b0}};
                end else begin
                    resp_data_d = alu_res;
                end
                resp_err_d = err_q;
`else
                resp_data_d = alu_res;
                resp_err_d  = 1'b0;
`endif
                resp_valid_d = owner_q ? 2'b10 : 2'b01;
                state_d      = S_RESP;
            end
            S_RESP: begin
                if (resp_ready[owner_q]) begin
                    resp_valid_d = 2'b00;
                    state_d      = S_IDLE;
                end else begin
                    state_d = S_RESP;
                end
            end
            default: begin
                resp_valid_d = 2'b00;
                state_d      = S_IDLE;
            end
        endcase
    end

    // State and output registers; reset discards any op in flight.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            last_q       <= 1'b1;
            owner_q      <= 1'b0;
            alu_in1_q    <= {WIDTH{1'b0}};
            alu_in2_q    <= {WIDTH{1'b0}};
            alu_op_q     <= {OP_W{1'b0}};
            resp_valid_q <= 2'b00;
            resp_data_q  <= {WIDTH{1'b0}};
            resp_err_q   <= 1'b0;
`ifdef ALU_ARB_OPCHK_EN
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            last_q       <= last_d;
            owner_q      <= owner_d;
            alu_in1_q    <= alu_in1_d;
            alu_in2_q    <= alu_in2_d;
            alu_op_q     <= alu_op_d;
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
`ifdef ALU_ARB_OPCHK_EN
            err_q        <= err_d;
`endif
        end
    end

    assign alu_in1    = alu_in1_q;
    assign alu_in2    = alu_in2_q;
    assign alu_op     = alu_op_q;
    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Directed bench for alu_share_arbiter with a behavioural ALU attached.
module tb_alu_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_ready, resp_valid, resp_ready;
    logic [31:0] req_a0, req_a1, req_b0, req_b1;
    logic [2:0]  req_op0, req_op1, alu_op;
    logic [31:0] resp_data, alu_in1, alu_in2, alu_res;
    logic        resp_err;

    int vec_cnt = 0;
    int miscmp_cnt = 0;

    alu_share_arbiter #(.WIDTH(32), .OP_W(3)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a0(req_a0), .req_a1(req_a1), .req_b0(req_b0), .req_b1(req_b1),
        .req_op0(req_op0), .req_op1(req_op1),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_data(resp_data), .resp_err(resp_err),
        .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_op(alu_op), .alu_res(alu_res)
    );

    always #5 clk = ~clk;

    // Behavioural shared ALU: add, sub, or, lui, signed compare; 0 for undefined ops.
    always_comb begin
        alu_res = 32'd0;
        case (alu_op)
            3'd0: alu_res = alu_in1 + alu_in2;
            3'd1: alu_res = alu_in1 - alu_in2;
            3'd2: alu_res = alu_in1 | alu_in2;
            3'd3: alu_res = {alu_in2[15:0], 16'd0};
            3'd4: begin
                if ($signed(alu_in1) == $signed(alu_in2))     alu_res = 32'd0;
                else if ($signed(alu_in1) > $signed(alu_in2)) alu_res = 32'd1;
                else                                          alu_res = 32'd2;
            end
            default: alu_res = 32'd0;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            miscmp_cnt++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Wait for requester g to be granted, then follow the op through EXEC and RESP.
    task automatic serve(input int g, input logic [31:0] ea, input logic [31:0] eb,
                         input logic [2:0] eop, input logic [31:0] ed, input logic ee);
        int n;
        logic [1:0] one_hot;
        one_hot = (g == 1) ? 2'b10 : 2'b01;
        n = 0;
        #1;
        while (req_ready == 2'b00 && n < 8) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("grant", 32'(req_ready), 32'(one_hot));
        @(posedge clk);
        @(negedge clk);
        req_valid[g] = 1'b0;
        #1;
        chk("exec_in1", alu_in1, ea);
        chk("exec_in2", alu_in2, eb);
        chk("exec_op", 32'(alu_op), 32'(eop));
        chk("exec_rvalid", 32'(resp_valid), 32'd0);
        chk("exec_rready", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("resp_valid", 32'(resp_valid), 32'(one_hot));
        chk("resp_data", resp_data, ed);
        chk("resp_err", 32'(resp_err), 32'(ee));
        chk("resp_rready", 32'(req_ready), 32'd0);
        resp_ready = one_hot;
        @(negedge clk);
        #1;
        chk("resp_done", 32'(resp_valid), 32'd0);
        resp_ready = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; req_valid = 2'b00; resp_ready = 2'b00;
        req_a0 = 32'd0; req_a1 = 32'd0; req_b0 = 32'd0; req_b1 = 32'd0;
        req_op0 = 3'd0; req_op1 = 3'd0;
        #1 reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        chk("rst_alu_in1", alu_in1, 32'd0);
        chk("rst_alu_in2", alu_in2, 32'd0);
        chk("rst_alu_op", 32'(alu_op), 32'd0);
        reset = 1'b1;

        // Single add from requester 0.
        req_valid = 2'b01; req_a0 = 32'd5; req_b0 = 32'd7; req_op0 = 3'd0;
        serve(0, 32'd5, 32'd7, 3'd0, 32'd12, 1'b0);

        // Fresh reset, then both valid: requester 0 first.
        reset = 1'b0; #2; reset = 1'b1;
        req_valid = 2'b11;
        req_a0 = 32'd10;   req_b0 = 32'd3;    req_op0 = 3'd1;
        req_a1 = 32'hF0;   req_b1 = 32'h0F;   req_op1 = 3'd2;
        serve(0, 32'd10, 32'd3, 3'd1, 32'd7, 1'b0);
        serve(1, 32'hF0, 32'h0F, 3'd2, 32'hFF, 1'b0);

        // Signed compares and lui.
        req_valid = 2'b10; req_a1 = 32'hFFFF_FFFD; req_b1 = 32'd2; req_op1 = 3'd4;
        serve(1, 32'hFFFF_FFFD, 32'd2, 3'd4, 32'd2, 1'b0);
        req_valid = 2'b10; req_a1 = 32'd2; req_b1 = 32'd2; req_op1 = 3'd4;
        serve(1, 32'd2, 32'd2, 3'd4, 32'd0, 1'b0);
        req_valid = 2'b01; req_a0 = 32'd0; req_b0 = 32'h1234; req_op0 = 3'd3;
        serve(0, 32'd0, 32'h1234, 3'd3, 32'h1234_0000, 1'b0);

        // Requester 0 just served: a tie now goes to requester 1.
        req_valid = 2'b11;
        req_a0 = 32'd1; req_b0 = 32'd1; req_op0 = 3'd0;
        req_a1 = 32'd5; req_b1 = 32'd6; req_op1 = 3'd1;
        serve(1, 32'd5, 32'd6, 3'd1, 32'hFFFF_FFFF, 1'b0);
        serve(0, 32'd1, 32'd1, 3'd0, 32'd2, 1'b0);

        // Response back-pressure with the other requester waiting.
        req_valid = 2'b01; req_a0 = 32'd100; req_b0 = 32'd23; req_op0 = 3'd0;
        #1 chk("stall_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b10; req_a1 = 32'd1; req_b1 = 32'd2; req_op1 = 3'd2;
        #1 chk("stall_exec_rdy", 32'(req_ready), 32'd0);
        @(negedge clk);
        #1;
        chk("stall_rvalid0", 32'(resp_valid), 32'd1);
        chk("stall_data0", resp_data, 32'd123);
        resp_ready = 2'b10;
        repeat (3) begin
            @(negedge clk);
            #1;
            chk("stall_rvalid", 32'(resp_valid), 32'd1);
            chk("stall_data", resp_data, 32'd123);
            chk("stall_rdy1", 32'(req_ready), 32'd0);
        end
        resp_ready = 2'b01;
        @(negedge clk);
        #1;
        chk("stall_done", 32'(resp_valid), 32'd0);
        chk("stall_rdy1_after", 32'(req_ready), 32'd2);
        resp_ready = 2'b00;
        serve(1, 32'd1, 32'd2, 3'd2, 32'd3, 1'b0);

        // Reset pulse while an op from requester 0 is in EXEC.
        req_valid = 2'b01; req_a0 = 32'd7; req_b0 = 32'd8; req_op0 = 3'd0;
        #1 chk("rx_grant", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid = 2'b00;
        #1 chk("rx_exec_in1", alu_in1, 32'd7);
        reset = 1'b0;
        #1;
        chk("rx_rvalid", 32'(resp_valid), 32'd0);
        chk("rx_alu_in1", alu_in1, 32'd0);
        chk("rx_alu_in2", alu_in2, 32'd0);
        chk("rx_alu_op", 32'(alu_op), 32'd0);
        #1 reset = 1'b1;
        repeat (2) begin
            @(negedge clk);
            #1 chk("rx_no_resp", 32'(resp_valid), 32'd0);
        end
        req_valid = 2'b11;
        req_a0 = 32'd3; req_b0 = 32'd4; req_op0 = 3'd0;
        req_a1 = 32'd9; req_b1 = 32'd9; req_op1 = 3'd1;
        serve(0, 32'd3, 32'd4, 3'd0, 32'd7, 1'b0);
        serve(1, 32'd9, 32'd9, 3'd1, 32'd0, 1'b0);

        // Undefined opcode 101.
        req_valid = 2'b01; req_a0 = 32'd1; req_b0 = 32'd2; req_op0 = 3'd5;
`ifdef ALU_ARB_OPCHK_EN
        serve(0, 32'd1, 32'd2, 3'd0, 32'd0, 1'b1);
`else
        serve(0, 32'd1, 32'd2, 3'd5, 32'd0, 1'b0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscmp_cnt);
        $finish;
    end

endmodule
